// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: arbitrates an instruction-fetch port and a data port onto
// one shared single-port memory with a fixed read latency of MEM_LAT cycles.
// Only one transaction is in flight at a time. The sequence is:
// IDLE (sample and grant) -> ISSUE (mem_en strobe) -> WAIT (latency count) ->
// RESP (ack pulse).
//
// Optional feature: define MEM_ARB_RR_EN to alternate grants when both ports
// request at once. When it is not defined, the data port always wins a tie.
module pipe_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  // data port
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_bytesel,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_ack,
  // shared memory
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_bytesel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  // pipeline hold controls
  output logic              stall_if,
  output logic              stall_mem
);

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] cnt;
  logic       win_dm;
  logic       any_req;
  logic       grant_dm;
  logic       issue_grant;
  logic       wait_done;

  assign any_req     = if_req | dm_req;
  assign issue_grant = (state == IDLE) && any_req;
  // WAIT ends on the cycle in which the count steps down to zero. A count
  // that is already zero also ends WAIT, so the FSM cannot get stuck there.
  assign wait_done   = (state == WAIT) && (cnt <= 3'd1);

`ifdef MEM_ARB_RR_EN
  // Records which port won the most recent grant: 1 = data, 0 = fetch.
  logic last_grant;

  // On a tie, grant the port that did not win last time.
  assign grant_dm = dm_req & (~if_req | ~last_grant);

  // Update the last-grant record at every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b0;
    end else if (issue_grant) begin
      last_grant <= grant_dm;
    end
  end
`else
  // Fixed priority: the data port wins any tie.
  assign grant_dm = dm_req;
`endif

  // Pipeline holds. These are combinational so that the hold drops in the
  // same cycle as the ack.
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = dm_req & ~dm_ack;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (cnt <= 3'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latency counter: loaded during the issue cycle, counted down in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 3'd0;
    end else if (state == ISSUE) begin
      cnt <= LAT_INIT;
    end else if ((state == WAIT) && (cnt != 3'd0)) begin
      cnt <= cnt - 3'd1;
    end
  end

  // Capture the winner's fields at the grant. The mem_* fields hold their
  // values until the next grant. mem_en is set only for the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_dm      <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_bytesel <= 2'b00;
      mem_addr    <= '0;
      mem_wdata   <= 32'd0;
    end else begin
      mem_en <= issue_grant;
      if (issue_grant) begin
        win_dm      <= grant_dm;
        mem_we      <= grant_dm & dm_we;
        mem_bytesel <= grant_dm ? dm_bytesel : 2'b00;
        mem_addr    <= grant_dm ? dm_addr : if_addr;
        mem_wdata   <= dm_wdata;
      end
    end
  end

  // Return path. The winner's rdata is captured at the end of WAIT, and its
  // ack is raised for the RESP cycle. A store leaves dm_rdata unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata <= 32'd0;
      dm_rdata <= 32'd0;
      if_ack   <= 1'b0;
      dm_ack   <= 1'b0;
    end else begin
      if_ack <= wait_done & ~win_dm;
      dm_ack <= wait_done & win_dm;
      if (wait_done) begin
        if (!win_dm) begin
          if_rdata <= mem_rdata;
        end else if (!mem_we) begin
          dm_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: doc/pipe_mem_arbiter.md
PIPE_MEM_ARBITER -- requirements
Module: pipe_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all address ports.
REQ-002 SHALL have parameter MEM_LAT, default 2, cycles from mem_en pulse to valid mem_rdata; legal 1..7.
REQ-003 Clock  in  1  single clock; all state updates on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  fetch port read request; held high until if_ack.
REQ-006 if_addr  in  ADDR_W  fetch address; stable while if_req high.
REQ-007 if_rdata  out  32  fetched instruction, registered.
REQ-008 if_ack  out  1  one-cycle pulse; if_rdata valid in the same cycle.
REQ-009 dm_req  in  1  data port request; held high until dm_ack.
REQ-010 dm_we  in  1  1 = store, 0 = load.
REQ-011 dm_bytesel  in  2  access size, passed to memory unchanged.
REQ-012 dm_addr  in  ADDR_W  data address; stable while dm_req high.
REQ-013 dm_wdata  in  32  store data; stable while dm_req high.
REQ-014 dm_rdata  out  32  load data, registered.
REQ-015 dm_ack  out  1  one-cycle pulse at completion of load or store.
REQ-016 mem_en  out  1  one-cycle issue strobe to the shared single-port memory.
REQ-017 mem_we  out  1  write strobe, qualified by mem_en.
REQ-018 mem_bytesel  out  2  access size to memory.
REQ-019 mem_addr  out  ADDR_W  memory address.
REQ-020 mem_wdata  out  32  memory write data.
REQ-021 mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en.
REQ-022 stall_if  out  1  combinational: if_req & ~if_ack; drives PC/IFID write-enable hold.
REQ-023 stall_mem  out  1  combinational: dm_req & ~dm_ack; freezes pipeline upstream of MEM.

Function
REQ-024 FSM SHALL have states IDLE, ISSUE, WAIT, RESP; one transaction in flight maximum.
REQ-025 IDLE: if any request, select winner, register winner id, addr, we (0 for fetch), bytesel (2'b00 for fetch), wdata; go ISSUE; else stay.
REQ-026 ISSUE: mem_en=1 for exactly one cycle with registered fields on mem_*; load counter with MEM_LAT; go WAIT.
REQ-027 WAIT: decrement counter each cycle; when counter reaches 0 capture mem_rdata into winner's rdata register; go RESP.
REQ-028 RESP: pulse winner's ack for one cycle; go IDLE; a new request is sampled in the following IDLE cycle.
REQ-029 Request-sampled to ack latency SHALL be MEM_LAT+2 cycles; back-to-back transactions occupy MEM_LAT+3 cycles each.
REQ-030 Stores SHALL follow the same timing; dm_rdata SHALL NOT change on a store.
REQ-031 Non-winner port's rdata and ack SHALL be unaffected by the transaction.
REQ-032 mem_we, mem_bytesel, mem_addr, mem_wdata SHALL hold the last issued values outside ISSUE; mem_en=0 outside ISSUE.
REQ-033 Request deasserted mid-transaction SHALL be ignored; transaction completes and ack still pulses.
REQ-034 Default (fixed priority): when both request in IDLE, data port wins.
REQ-035 Counter SHALL be 3 bits; MEM_LAT outside 1..7 is unsupported.

Reset
REQ-036 Reset SHALL force IDLE, counter 0, mem_en 0, mem_we 0, mem_bytesel 0, mem_addr 0, mem_wdata 0, if_rdata 0, dm_rdata 0, if_ack 0, dm_ack 0, last-grant bit 0.
REQ-037 Reset in any state SHALL abort the transaction with no ack; Reset overrides all inputs in that cycle.

Configuration
REQ-038 With MEM_ARB_RR_EN defined: on simultaneous requests, grant the port not granted last (last-grant bit updated at each grant, 0 = fetch); single requests granted directly.
REQ-039 Without MEM_ARB_RR_EN: fixed priority per REQ-034; last-grant bit absent.

Verification (MEM_LAT=2)
REQ-040 if_req=1, if_addr=0x40, mem_rdata=0x2002000A at the WAIT exit -> mem_en pulse 1 cycle after sample, if_ack 4 cycles after sample, if_rdata=0x2002000A.
REQ-041 dm_req store, dm_addr=0x100, dm_wdata=0xDEADBEEF, bytesel=2'b01 -> mem_en=1, mem_we=1, mem_bytesel=2'b01 same cycle; dm_ack 4 cycles after sample; dm_rdata unchanged.
REQ-042 if_req and dm_req high continuously, fixed priority -> dm granted every transaction, if_ack never pulses, stall_if stays 1; with MEM_ARB_RR_EN -> grants alternate dm, if, dm, if, every 5 cycles.
REQ-043 Reset asserted in WAIT -> next cycle IDLE, no ack, mem_en 0, rdata registers 0.
REQ-044 if_req dropped in WAIT -> if_ack still pulses in RESP; next IDLE issues nothing if no request.
